data_sram_resp: RTL and testbench
=================================

# data_sram_resp

Data-side memory responder for the five-stage core. It accepts the EX-stage data SRAM request (enable, byte write enables, address, write data) and performs byte-lane writes and whole-word reads. Read data is presented to the MEM stage in the cycle after the request leaves EX. A parameterised wait-state counter stalls the pipeline for slow-memory emulation, and a hold state prevents re-issuing a request that the rest of the pipeline keeps frozen in EX.

## Interface
- ADDR_W, 10, log2 of depth in 32-bit words; word index = data_sram_addr[ADDR_W+1:2], higher bits ignored (aliasing).
- WAIT_CYCLES, 0, wait states per access, legal 0..15.

- clk  input  1  single clock, all state on rising edge
- rst  input  1  asynchronous, active-low reset
- data_sram_en  input  1  request valid this cycle (from EX)
- data_sram_wen  input  4  byte write enables, bit i -> byte lane i (bits 8i+7:8i); 0 = read
- data_sram_addr  input  32  byte address; bits 1:0 ignored
- data_sram_wdata  input  32  write data, already lane-aligned by EX
- ext_stall  input  1  1 = EX/MEM register is held this cycle by another stall source
- data_sram_rdata  output  32  registered read word, consumed by MEM
- stall_req  output  1  combinational stall request to the stall controller (freezes PC..EX)

## Operation
- State machine states are IDLE, WAIT, and DONE. A 4-bit counter `cnt` tracks wait cycles.
- **IDLE:**
  - If en=0, there is no action and stall_req=0.
  - If en=1 and WAIT_CYCLES=0, the access is performed at this edge. If ext_stall=1, go to DONE; otherwise stay in IDLE.
  - If en=1 and WAIT_CYCLES>0, assert stall_req=1, set cnt<=1, and go to WAIT.
- **WAIT:**
  - stall_req = (cnt < WAIT_CYCLES).
  - If cnt < WAIT_CYCLES, increment cnt.
  - If cnt == WAIT_CYCLES, the access is performed at this edge and cnt<=0. Next state is DONE if ext_stall=1, else IDLE.
  - If en=0 in WAIT (flush), abort: no write occurs, rdata is unchanged, go to IDLE, cnt<=0, and stall_req=0 that cycle.
- **DONE:**
  - The request is complete, and the same request is still presented because the pipeline is held.
  - stall_req=0. No access is performed and there is no re-issue.
  - Stay in DONE while ext_stall=1. Go to IDLE when ext_stall=0, since the request leaves EX at that edge.
- **Access definition:**
  - Write (wen!=0): for each i with wen[i]=1, mem[idx] byte i <= wdata byte i. Other lanes are unchanged. data_sram_rdata is unchanged.
  - Read (wen=0): data_sram_rdata <= mem[idx].
- data_sram_rdata holds its value until the next completed read. This keeps MEM data stable across MEM-stage stalls.
- Byte/half extraction and sign extension are not done here; MEM does them.

## Timing
- **Reset (rst=0, asynchronous):**
  - state=IDLE, cnt=0, data_sram_rdata=32'h0.
  - stall_req is forced to 0 while rst=0.
  - Memory array contents are not reset (undefined until written).
- **Read latency:** request in cycle t with WAIT_CYCLES=N and ext_stall=0:
  - stall_req=1 in cycles t..t+N-1 (never asserted for N=0).
  - The access occurs at the edge ending cycle t+N.
  - rdata is valid from cycle t+N+1, the cycle the request occupies MEM.
- **Back-to-back:** a new request in the cycle after completion (state IDLE) starts immediately, giving N=0 full throughput.
- **Read-after-write to the same word in consecutive requests:** the read returns the newly written bytes, because the write commits at the earlier edge.
- **Address aliasing:** addr 32'h0000_1000 and 32'h0000_0000 hit the same word when ADDR_W=10.
- **Reset mid-WAIT:** the access is discarded and no write occurs.

## Test plan
- **Read, no wait.** Settings: N=0; preload mem[4]=32'hDEAD_BEEF.
  - Stimulus: en=1, wen=0, addr=32'h10 in cycle t.
  - Required response: rdata=32'hDEAD_BEEF from t+1; stall_req=0 throughout.
- **Byte-lane write, then read.** Settings: N=0; mem[0] initially 32'h1122_3344.
  - Stimulus: write wen=4'b0100, wdata=32'h00AB_0000, addr=0; then read addr=0.
  - Required response: rdata=32'h11AB_3344 on the cycle after the read.
- **Wait states.** Setting: N=3.
  - Stimulus: read addr=32'h8 held with en=1.
  - Required response: stall_req high for exactly 3 cycles; rdata updates exactly 4 cycles after first en; no second access.
- **External hold.** Setting: N=2.
  - Stimulus: ext_stall=1 for 3 cycles starting at completion; request kept presented.
  - Required response: state DONE; stall_req=0; exactly one write to the array (verify by interleaving a backdoor change then read).
- **Flush mid-WAIT.** Setting: N=4.
  - Stimulus: write 32'hFFFF_FFFF to addr 0x20; drop en after 2 cycles.
  - Required response: stall_req falls the same cycle; mem[8] unchanged; next request is accepted normally.
- **Async reset mid-WAIT.** Stimulus: pulse rst low mid-WAIT between clock edges.
  - Required response: rdata=0 and stall_req=0 immediately; state IDLE; the pending write is not committed.

Source files
------------

// File: rtl/data_sram_resp.sv
// data_sram_resp: data-side memory responder for the five-stage core.
// Accepts the EX-stage data SRAM request, performs byte-lane writes and
// whole-word reads, inserts WAIT_CYCLES wait states (0..15), and parks in a
// hold state so a request frozen in EX by another stall is not re-issued.
//
// Parameters:
//   ADDR_W       log2 of depth in 32-bit words; word index = addr[ADDR_W+1:2]
//   WAIT_CYCLES  wait states per access, legal range 0..15
// Ports:
//   clk              clock, all state on rising edge
//   rst              asynchronous active-low reset
//   data_sram_en     request valid this cycle
//   data_sram_wen    byte write enables (bit i -> bits 8i+7:8i), 0 = read
//   data_sram_addr   byte address, bits 1:0 and bits above ADDR_W+1 ignored
//   data_sram_wdata  lane-aligned write data
//   ext_stall        EX/MEM register held this cycle by another stall source
//   data_sram_rdata  registered read word, held until the next completed read
//   stall_req        combinational stall request to the stall controller
module data_sram_resp #(
    parameter int unsigned ADDR_W      = 10,
    parameter int unsigned WAIT_CYCLES = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        data_sram_en,
    input  logic [3:0]  data_sram_wen,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    input  logic        ext_stall,
    output logic [31:0] data_sram_rdata,
    output logic        stall_req
);

    localparam int unsigned DEPTH    = 1 << ADDR_W;
    localparam int unsigned CNT_W    = 4;
    localparam int unsigned LANES    = 4;
    localparam logic [CNT_W-1:0] WAIT_N = CNT_W'(WAIT_CYCLES);
    localparam logic HAS_WAIT = (WAIT_CYCLES != 0);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [31:0]       mem [DEPTH];
    logic [ADDR_W-1:0] idx;
    logic              is_write;
    logic              access;
    logic              unused_addr;

    assign idx         = data_sram_addr[ADDR_W+1:2];
    assign is_write    = |data_sram_wen;
    assign unused_addr = ^{data_sram_addr[31:ADDR_W+2], data_sram_addr[1:0]};

    // Access strobe and stall request; both forced low while reset is held.
    // In WAIT the counter never exceeds WAIT_N, so != stands in for <.
    always_comb begin
        access    = 1'b0;
        stall_req = 1'b0;
        unique case (state)
            IDLE: begin
                access    = data_sram_en && !HAS_WAIT;
                stall_req = data_sram_en && HAS_WAIT;
            end
            WAIT: begin
                access    = data_sram_en && (cnt == WAIT_N);
                stall_req = data_sram_en && (cnt != WAIT_N);
            end
            default: begin
                access    = 1'b0;
                stall_req = 1'b0;
            end
        endcase
        if (!rst) begin
            access    = 1'b0;
            stall_req = 1'b0;
        end
    end

    // Control FSM, wait counter and read-data register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state           <= IDLE;
            cnt             <= '0;
            data_sram_rdata <= '0;
        end else begin
            if (access && !is_write) begin
                data_sram_rdata <= mem[idx];
            end
            unique case (state)
                IDLE: begin
                    if (data_sram_en) begin
                        if (HAS_WAIT) begin
                            cnt   <= CNT_W'(1);
                            state <= WAIT;
                        end else if (ext_stall) begin
                            state <= DONE;
                        end
                    end
                end
                WAIT: begin
                    if (!data_sram_en) begin
                        // flush from EX: abandon the access
                        cnt   <= '0;
                        state <= IDLE;
                    end else if (cnt != WAIT_N) begin
                        cnt <= cnt + CNT_W'(1);
                    end else begin
                        cnt   <= '0;
                        state <= ext_stall ? DONE : IDLE;
                    end
                end
                DONE: begin
                    // request already served; wait for it to leave EX
                    if (!ext_stall) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    cnt   <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

    // Storage array with byte-lane write enables; not reset.
    always_ff @(posedge clk) begin
        if (access) begin
            for (int i = 0; i < LANES; i++) begin
                if (data_sram_wen[i]) begin
                    mem[idx][8*i +: 8] <= data_sram_wdata[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_data_sram_resp.sv
// tb_data_sram_resp: bench for data_sram_resp. Two instances (0 and 3 wait
// states) are driven with directed and random transactions and checked
// against a transaction-level reference model of the memory and read port.
module tb_data_sram_resp;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en    [2];
    logic [3:0]  wen   [2];
    logic [31:0] addr  [2];
    logic [31:0] wdata [2];
    logic        ext   [2];
    logic [31:0] rdata [2];
    logic        stall [2];

    int total = 0;
    int bad   = 0;

    // reference model: word array per instance, expected read register
    logic [31:0] model_mem [2][1024];
    logic [31:0] exp_rd    [2];
    int          nwait     [2];

    always #5 clk = ~clk;

    data_sram_resp #(.ADDR_W(10), .WAIT_CYCLES(0)) u_n0 (
        .clk(clk), .rst(rst),
        .data_sram_en(en[0]), .data_sram_wen(wen[0]),
        .data_sram_addr(addr[0]), .data_sram_wdata(wdata[0]),
        .ext_stall(ext[0]),
        .data_sram_rdata(rdata[0]), .stall_req(stall[0])
    );

    data_sram_resp #(.ADDR_W(10), .WAIT_CYCLES(3)) u_n3 (
        .clk(clk), .rst(rst),
        .data_sram_en(en[1]), .data_sram_wen(wen[1]),
        .data_sram_addr(addr[1]), .data_sram_wdata(wdata[1]),
        .ext_stall(ext[1]),
        .data_sram_rdata(rdata[1]), .stall_req(stall[1])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One request on instance w. hold = cycles of ext_stall from completion;
    // flush_at >= 0 drops en in that cycle of the request (abort).
    task automatic do_req(input int w, input logic [3:0] wn, input logic [31:0] a,
                          input logic [31:0] d, input int hold, input int flush_at);
        int          k;
        int          stalls;
        bit          done_ok;
        bit          flushed;
        logic [31:0] nr;
        k       = int'(a[11:2]);
        stalls  = 0;
        done_ok = 1'b0;
        flushed = 1'b0;
        @(negedge clk);
        en[w] = 1'b1; wen[w] = wn; addr[w] = a; wdata[w] = d; ext[w] = 1'b0;
        for (int c = 0; c < 20; c++) begin
            #1;
            if (flush_at >= 0 && c == flush_at) begin
                en[w] = 1'b0;
                #1;
                check("flush_stall", 32'(stall[w]), 32'd0);
                flushed = 1'b1;
                break;
            end
            check("rdata_before_access", rdata[w], exp_rd[w]);
            if (!stall[w]) begin
                done_ok = 1'b1;
                break;
            end
            stalls++;
            @(negedge clk);
        end
        if (flushed) begin
            @(negedge clk);
            #1;
            check("flush_rdata", rdata[w], exp_rd[w]);
            check("flush_no_stall", 32'(stall[w]), 32'd0);
        end else begin
            check("stall_cycles", 32'(stalls), 32'(nwait[w]));
            if (!done_ok) begin
                $display("FAIL timeout waiting for completion on instance %0d", w);
            end
            // access happens at the coming edge
            nr = exp_rd[w];
            if (wn == 4'h0) begin
                nr = model_mem[w][k];
            end else begin
                for (int i = 0; i < 4; i++) begin
                    if (wn[i]) model_mem[w][k][8*i +: 8] = d[8*i +: 8];
                end
            end
            ext[w] = (hold > 0);
            for (int h = 1; h <= hold; h++) begin
                @(negedge clk);
                ext[w]   = (h < hold);
                wdata[w] = ~d;  // a re-issued write would store this
                #1;
                check("hold_stall", 32'(stall[w]), 32'd0);
                check("hold_rdata", rdata[w], nr);
            end
            @(negedge clk);
            en[w] = 1'b0; ext[w] = 1'b0; wen[w] = 4'h0;
            #1;
            exp_rd[w] = nr;
            check("rdata", rdata[w], exp_rd[w]);
        end
        en[w] = 1'b0; ext[w] = 1'b0; wen[w] = 4'h0;
    endtask

    function automatic logic [31:0] rand_addr(input int k);
        logic [31:0] r;
        r = $urandom();
        return {r[31:12], 6'b0, 4'(k), r[1:0]};
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] v;
        logic [3:0]  wn;
        int          w;
        nwait[0] = 0;
        nwait[1] = 3;
        for (int i = 0; i < 2; i++) begin
            en[i] = 1'b0; wen[i] = 4'h0; addr[i] = '0; wdata[i] = '0; ext[i] = 1'b0;
            exp_rd[i] = 32'h0;
        end

        // reset state, with a request presented on the wait-state instance
        en[1] = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("reset_rdata0", rdata[0], 32'h0);
        check("reset_rdata1", rdata[1], 32'h0);
        check("reset_stall1", 32'(stall[1]), 32'd0);
        en[1] = 1'b0;
        #1;
        rst = 1'b1;

        // preload words 0..15 on both instances through the write port
        for (int i = 0; i < 2; i++) begin
            for (int k = 0; k < 16; k++) begin
                v = $urandom();
                if (k == 4) v = 32'hDEAD_BEEF;
                if (k == 0) v = 32'h1122_3344;
                do_req(i, 4'hF, 32'(k) << 2, v, 0, -1);
            end
        end

        // read without wait states
        do_req(0, 4'h0, 32'h10, 32'h0, 0, -1);
        check("read_deadbeef", rdata[0], 32'hDEAD_BEEF);

        // byte-lane write then read of the same word
        do_req(0, 4'b0100, 32'h0, 32'h00AB_0000, 0, -1);
        do_req(0, 4'h0, 32'h0, 32'h0, 0, -1);
        check("lane_merge", rdata[0], 32'h11AB_3344);

        // aliasing: 0x1000 and 0x0 hit the same word
        do_req(0, 4'hF, 32'h0000_1000, 32'hCAFE_F00D, 0, -1);
        do_req(0, 4'h0, 32'h0, 32'h0, 0, -1);
        check("alias", rdata[0], 32'hCAFE_F00D);

        // wait states: read held until completion
        do_req(1, 4'h0, 32'h8, 32'h0, 0, -1);

        // external hold: write completes once, then read back
        do_req(1, 4'hF, 32'h30, 32'h5A5A_A5A5, 3, -1);
        do_req(1, 4'h0, 32'h30, 32'h0, 0, -1);
        check("hold_single_write", rdata[1], 32'h5A5A_A5A5);
        do_req(0, 4'b0011, 32'h34, 32'h0000_1234, 2, -1);
        do_req(0, 4'h0, 32'h34, 32'h0, 1, -1);

        // flush mid-WAIT, then a normal request
        do_req(1, 4'hF, 32'h20, 32'hFFFF_FFFF, 0, 2);
        do_req(1, 4'h0, 32'h20, 32'h0, 0, -1);

        // asynchronous reset mid-WAIT
        @(negedge clk);
        en[1] = 1'b1; wen[1] = 4'hF; addr[1] = 32'h20; wdata[1] = 32'hFFFF_FFFF;
        @(negedge clk);
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("arst_rdata0", rdata[0], 32'h0);
        check("arst_rdata1", rdata[1], 32'h0);
        check("arst_stall1", 32'(stall[1]), 32'd0);
        exp_rd[0] = 32'h0;
        exp_rd[1] = 32'h0;
        en[1] = 1'b0; wen[1] = 4'h0;
        #1;
        rst = 1'b1;
        do_req(1, 4'h0, 32'h20, 32'h0, 0, -1);

        // random traffic on both instances
        for (int n = 0; n < 120; n++) begin
            w  = int'($urandom_range(0, 1));
            wn = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            v  = $urandom();
            if (w == 1 && $urandom_range(0, 9) == 0) begin
                do_req(w, wn, rand_addr(int'($urandom_range(0, 15))), v, 0,
                       int'($urandom_range(0, 2)));
            end else begin
                do_req(w, wn, rand_addr(int'($urandom_range(0, 15))), v,
                       int'($urandom_range(0, 2)), -1);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
